// File: rtl/dds_multi_gen.sv
// rtl/dds_multi_gen.sv - N-channel DDS generator with shadowed config and linear sweep
// Config writes land in shadows and commit at phase wrap or sync; samples trail sample_en by two cycles.
module dds_multi_gen #(
    parameter int               CH_NUM        = 2,
    parameter int               ACC_W         = 32,
    parameter int               DATA_W        = 8,
    parameter logic [ACC_W-1:0] FREQ_DEFAULT  = ACC_W'(3615292),
    parameter logic [ACC_W-1:0] PHASE_DEFAULT = '0,
    parameter logic [3:0]       MODE_DEFAULT  = 4'd1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [2:0]               cfg_ch,
    input  logic [2:0]               cfg_addr,
    input  logic [ACC_W-1:0]         cfg_data,
    output logic                     cfg_err,
    input  logic                     sample_en,
    output logic [CH_NUM*DATA_W-1:0] dac_data,
    output logic                     dac_valid,
    output logic [CH_NUM-1:0]        wrap_pulse
);

    localparam logic [2:0] A_FREQ  = 3'd0;
    localparam logic [2:0] A_PHASE = 3'd1;
    localparam logic [2:0] A_MODE  = 3'd2;
    localparam logic [2:0] A_STOP  = 3'd3;
    localparam logic [2:0] A_STEP  = 3'd4;
    localparam logic [2:0] A_SYNC  = 3'd7;

    typedef enum logic {S_IDLE, S_PEND} ch_state_t;

    logic r_ready;
    logic r_err;
    logic r_en1;
    logic r_dvalid;

    logic w_accept;
    logic w_sync_all;
    logic w_ch_ok;
    logic w_addr_bad;
    logic w_bad;
    logic w_good;

    assign w_accept   = cfg_valid & r_ready;
    // A broadcast sync ignores cfg_ch, so an out-of-range channel is not an error there.
    assign w_sync_all = (cfg_addr == A_SYNC) & cfg_data[0];
    assign w_ch_ok    = ({29'd0, cfg_ch} < CH_NUM) | w_sync_all;
    assign w_addr_bad = (cfg_addr == 3'd5) | (cfg_addr == 3'd6);
    assign w_bad      = w_accept & (~w_ch_ok | w_addr_bad);
    assign w_good     = w_accept & ~w_bad;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ready  <= 1'b0;
            r_err    <= 1'b0;
            r_en1    <= 1'b0;
            r_dvalid <= 1'b0;
        end else begin
            r_ready  <= ~w_accept;
            r_err    <= w_bad;
            r_en1    <= sample_en;
            r_dvalid <= r_en1;
        end
    end

    assign cfg_ready = r_ready;
    assign cfg_err   = r_err;
    assign dac_valid = r_dvalid;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        ch_state_t         r_state;
        logic [ACC_W-1:0]  r_acc;
        logic [ACC_W-1:0]  r_freq;
        logic [ACC_W-1:0]  r_sfreq;
        logic [ACC_W-1:0]  r_phase;
        logic [ACC_W-1:0]  r_sphase;
        logic [ACC_W-1:0]  r_stop;
        logic [ACC_W-1:0]  r_step;
        logic [3:0]        r_mode;
        logic [3:0]        r_smode;
        logic [DATA_W-1:0] r_dac;
        logic              r_wrap;

        logic                    w_sel;
        logic                    w_sync;
        logic                    w_wr_shadow;
        logic [ACC_W:0]          w_sum;
        logic [ACC_W:0]          w_sweep;
        logic                    w_wrap;
        logic                    w_commit;
        logic [DATA_W-1:0]       w_p;
        logic [ACC_W-DATA_W-1:0] w_unused_frac;
        logic [DATA_W-1:0]       w_wave;

        assign w_sel       = w_good & (cfg_ch == 3'(g));
        assign w_sync      = w_good & (cfg_addr == A_SYNC) & (cfg_data[0] | (cfg_ch == 3'(g)));
        assign w_wr_shadow = w_sel & (cfg_addr <= A_MODE);
        assign w_sum       = {1'b0, r_acc} + {1'b0, r_freq};
        assign w_sweep     = {1'b0, r_freq} + {1'b0, r_step};
        // Sync clears the accumulator, which overrides any carry from the same edge.
        assign w_wrap      = sample_en & w_sum[ACC_W] & ~w_sync;
        assign w_commit    = (r_state == S_PEND) & (w_sync | w_wrap);

        assign {w_p, w_unused_frac} = r_acc + r_phase;

        always_comb begin
            w_wave = {1'b1, {(DATA_W-1){1'b0}}};
            case (r_mode[2:0])
                3'd1:    w_wave = {DATA_W{w_p[DATA_W-1]}};
                3'd2:    w_wave = w_p;
                3'd3:    w_wave = w_p[DATA_W-1] ? ~{w_p[DATA_W-2:0], 1'b0} : {w_p[DATA_W-2:0], 1'b0};
                default: ;
            endcase
        end

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_state  <= S_IDLE;
                r_acc    <= '0;
                r_freq   <= FREQ_DEFAULT;
                r_sfreq  <= FREQ_DEFAULT;
                r_phase  <= PHASE_DEFAULT;
                r_sphase <= PHASE_DEFAULT;
                r_mode   <= MODE_DEFAULT;
                r_smode  <= MODE_DEFAULT;
                r_stop   <= '0;
                r_step   <= '0;
                r_dac    <= '0;
                r_wrap   <= 1'b0;
            end else begin
                r_wrap <= w_wrap;

                if (w_sync) begin
                    r_acc <= '0;
                end else if (sample_en) begin
                    r_acc <= w_sum[ACC_W-1:0];
                end

                // Commit reads the shadows before any same-cycle write lands in them.
                if (w_commit) begin
                    r_freq  <= r_sfreq;
                    r_phase <= r_sphase;
                    r_mode  <= r_smode;
                end else if (w_wrap && r_mode[3]) begin
                    r_freq <= (w_sweep > {1'b0, r_stop}) ? r_sfreq : w_sweep[ACC_W-1:0];
                end

                if (w_sel) begin
                    case (cfg_addr)
                        A_FREQ:  r_sfreq  <= cfg_data;
                        A_PHASE: r_sphase <= cfg_data;
                        A_MODE:  r_smode  <= cfg_data[3:0];
                        A_STOP:  r_stop   <= cfg_data;
                        A_STEP:  r_step   <= cfg_data;
                        default: ;
                    endcase
                end

                case (r_state)
                    S_IDLE: if (w_wr_shadow) r_state <= S_PEND;
                    S_PEND: if (w_commit && !w_wr_shadow) r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase

                if (r_en1) begin
                    r_dac <= w_wave;
                end
            end
        end

        assign dac_data[g*DATA_W +: DATA_W] = r_dac;
        assign wrap_pulse[g]                = r_wrap;
    end

endmodule

// File: tb/tb_dds_multi_gen.sv
// tb/tb_dds_multi_gen.sv - randomized self-checking bench for dds_multi_gen
// A cycle-level reference model tracks the specified behaviour from the bench's own input stream.
module tb_dds_multi_gen;

    localparam int              CH    = 2;
    localparam longint unsigned TWO32 = 64'h1_0000_0000;
    localparam logic [31:0]     FDEF  = 32'd3615292;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_ch;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_err;
    logic        sample_en;
    logic [15:0] dac_data;
    logic        dac_valid;
    logic [1:0]  wrap_pulse;

    dds_multi_gen #(.CH_NUM(2), .ACC_W(32), .DATA_W(8)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_err    (cfg_err),
        .sample_en  (sample_en),
        .dac_data   (dac_data),
        .dac_valid  (dac_valid),
        .wrap_pulse (wrap_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_acc[CH], m_freq[CH], m_sfreq[CH], m_phase[CH], m_sphase[CH], m_stop[CH], m_step[CH];
    logic [3:0]  m_mode[CH], m_smode[CH];
    logic        m_pend[CH];
    logic [7:0]  m_dac[CH];
    logic [1:0]  m_wrap;
    logic        m_ready, m_err, m_en1, m_dvalid;
    logic [20:0] expv, obs;

    function automatic logic [7:0] wave(input logic [31:0] acc, input logic [31:0] ph, input logic [3:0] mode);
        longint unsigned pos;
        int p;
        pos = ({32'd0, acc} + {32'd0, ph}) % TWO32;
        p   = int'(pos / 64'd16777216);
        case (int'(mode) % 8)
            1:       return (p >= 128) ? 8'd255 : 8'd0;
            2:       return 8'(p);
            3:       return (p < 128) ? 8'(2 * p) : 8'(511 - 2 * p);
            default: return 8'd128;
        endcase
    endfunction

    task automatic m_reset();
        for (int c = 0; c < CH; c++) begin
            m_acc[c]   = 32'd0;
            m_freq[c]  = FDEF;
            m_sfreq[c] = FDEF;
            m_phase[c] = 32'd0;
            m_sphase[c] = 32'd0;
            m_mode[c]  = 4'd1;
            m_smode[c] = 4'd1;
            m_stop[c]  = 32'd0;
            m_step[c]  = 32'd0;
            m_pend[c]  = 1'b0;
            m_dac[c]   = 8'd0;
        end
        m_wrap = 2'b00;
        m_ready = 1'b0;
        m_err = 1'b0;
        m_en1 = 1'b0;
        m_dvalid = 1'b0;
        expv = 21'd0;
    endtask

    task automatic m_edge();
        logic accept, bad, good, sync, wrapped;
        longint unsigned sum, n;
        if (!sys_rst_n) begin
            m_reset();
            return;
        end
        accept = cfg_valid && m_ready;
        bad = accept && ((int'(cfg_ch) >= CH && !(cfg_addr == 3'd7 && cfg_data[0])) ||
                         cfg_addr == 3'd5 || cfg_addr == 3'd6);
        good = accept && !bad;
        for (int c = 0; c < CH; c++) begin
            if (m_en1) m_dac[c] = wave(m_acc[c], m_phase[c], m_mode[c]);
        end
        m_dvalid = m_en1;
        m_en1 = sample_en;
        m_err = bad;
        m_ready = !accept;
        for (int c = 0; c < CH; c++) begin
            sync = good && cfg_addr == 3'd7 && (cfg_data[0] || int'(cfg_ch) == c);
            sum = {32'd0, m_acc[c]} + {32'd0, m_freq[c]};
            wrapped = sample_en && sum >= TWO32 && !sync;
            m_wrap[c] = wrapped;
            if (sync) m_acc[c] = 32'd0;
            else if (sample_en) m_acc[c] = 32'(sum % TWO32);
            if (m_pend[c] && (sync || wrapped)) begin
                m_freq[c] = m_sfreq[c];
                m_phase[c] = m_sphase[c];
                m_mode[c] = m_smode[c];
                m_pend[c] = 1'b0;
            end else if (wrapped && m_mode[c] >= 4'd8) begin
                n = {32'd0, m_freq[c]} + {32'd0, m_step[c]};
                m_freq[c] = (n > {32'd0, m_stop[c]}) ? m_sfreq[c] : 32'(n);
            end
            if (good && int'(cfg_ch) == c) begin
                case (cfg_addr)
                    3'd0: begin m_sfreq[c] = cfg_data; m_pend[c] = 1'b1; end
                    3'd1: begin m_sphase[c] = cfg_data; m_pend[c] = 1'b1; end
                    3'd2: begin m_smode[c] = cfg_data[3:0]; m_pend[c] = 1'b1; end
                    3'd3: m_stop[c] = cfg_data;
                    3'd4: m_step[c] = cfg_data;
                    default: ;
                endcase
            end
        end
        expv = {m_dvalid, m_dac[1], m_dac[0], m_wrap, m_ready, m_err};
    endtask

    task automatic tick();
        @(posedge sys_clk);
        m_edge();
        #1;
        obs = {dac_valid, dac_data, wrap_pulse, cfg_ready, cfg_err};
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [2:0] addr, input logic [31:0] data);
        logic was_ready;
        cfg_valid = 1'b1;
        cfg_ch = ch;
        cfg_addr = addr;
        cfg_data = data;
        for (int i = 0; i < 3; i++) begin
            was_ready = m_ready;
            tick();
            if (was_ready) break;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch = 3'd0;
        cfg_addr = 3'd0;
        cfg_data = 32'd0;
        sample_en = 1'b0;
        m_reset();
        repeat (3) tick();
        checks++;
        if (obs !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", obs);
        end
        #2 sys_rst_n = 1'b1;
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b exp 1", cfg_ready);
        end
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset_model got %h exp %h", obs, expv);
        end
    endtask

    task automatic test_saw();
        int last, n_int;
        sample_en = 1'b0;
        cfg_write(3'd0, 3'd0, 32'h0100_0000);
        cfg_write(3'd0, 3'd2, 32'd2);
        cfg_write(3'd0, 3'd7, 32'd0);
        sample_en = 1'b1;
        last = -1;
        n_int = 0;
        for (int i = 0; i < 700; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL saw cycle %0d got %h exp %h", i, obs, expv);
            end
            if (wrap_pulse[0] === 1'b1) begin
                if (last >= 0) begin
                    n_int++;
                    checks++;
                    if (i - last != 256) begin
                        errors++;
                        $display("FAIL saw_wrap_interval got %0d exp 256", i - last);
                    end
                end
                last = i;
            end
        end
        checks++;
        if (n_int < 1) begin
            errors++;
            $display("FAIL saw_wrap_count got %0d exp >=1", n_int);
        end
    endtask

    task automatic test_pend_write();
        logic found;
        sample_en = 1'b0;
        cfg_write(3'd1, 3'd2, 32'd2);
        cfg_write(3'd1, 3'd0, 32'h1000_0000);
        cfg_write(3'd1, 3'd7, 32'd0);
        sample_en = 1'b1;
        repeat (5) tick();
        cfg_write(3'd1, 3'd0, 32'h0800_0000);
        for (int i = 0; i < 60; i++) begin
            sample_en = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL pend_mid cycle %0d got %h exp %h", i, obs, expv);
            end
        end
        cfg_write(3'd1, 3'd0, 32'h0400_0000);
        sample_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_ready && ({32'd0, m_acc[1]} + {32'd0, m_freq[1]}) >= TWO32) begin
                found = 1'b1;
            end else begin
                tick();
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL pend_seek cycle %0d got %h exp %h", i, obs, expv);
                end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL pend_wrap_timeout got 0 exp 1");
        end
        cfg_write(3'd1, 3'd0, 32'h2000_0000);
        for (int i = 0; i < 120; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL pend_wrapwrite cycle %0d got %h exp %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_phase_sync();
        sample_en = 1'b0;
        cfg_write(3'd0, 3'd2, 32'd1);
        cfg_write(3'd1, 3'd2, 32'd1);
        cfg_write(3'd0, 3'd0, 32'h0400_0000);
        cfg_write(3'd1, 3'd0, 32'h0400_0000);
        cfg_write(3'd1, 3'd1, 32'h8000_0000);
        cfg_write(3'd5, 3'd7, 32'd1);
        for (int i = 0; i < 150; i++) begin
            sample_en = (i < 75) ? 1'b1 : ($urandom_range(0, 1) == 1);
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL phase_sync cycle %0d got %h exp %h", i, obs, expv);
            end
        end
    endtask

    task automatic test_sweep();
        int wt[5];
        int nw;
        sample_en = 1'b0;
        cfg_write(3'd0, 3'd0, 32'h0100_0000);
        cfg_write(3'd0, 3'd2, 32'hA);
        cfg_write(3'd0, 3'd3, 32'h0300_0000);
        cfg_write(3'd0, 3'd4, 32'h0100_0000);
        cfg_write(3'd0, 3'd7, 32'd0);
        sample_en = 1'b1;
        nw = 0;
        for (int i = 0; i < 900; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL sweep cycle %0d got %h exp %h", i, obs, expv);
            end
            if (wrap_pulse[0] === 1'b1 && nw < 5) begin
                wt[nw] = i;
                nw++;
            end
        end
        checks++;
        if (nw < 4) begin
            errors++;
            $display("FAIL sweep_wrap_count got %0d exp >=4", nw);
        end else begin
            checks++;
            if (wt[1] - wt[0] != 128) begin
                errors++;
                $display("FAIL sweep_int1 got %0d exp 128", wt[1] - wt[0]);
            end
            checks++;
            if (wt[2] - wt[1] != 86) begin
                errors++;
                $display("FAIL sweep_int2 got %0d exp 86", wt[2] - wt[1]);
            end
            checks++;
            if (wt[3] - wt[2] != 254) begin
                errors++;
                $display("FAIL sweep_int3 got %0d exp 254", wt[3] - wt[2]);
            end
        end
    endtask

    task automatic test_bad_cfg();
        logic [2:0] bch[5] = '{3'd7, 3'd0, 3'd1, 3'd3, 3'd0};
        logic [2:0] bad[5] = '{3'd0, 3'd5, 3'd6, 3'd7, 3'd3};
        logic       berr[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 5; k++) begin
            sample_en = $urandom_range(0, 1) == 1;
            cfg_write(bch[k], bad[k], $urandom & 32'hFFFF_FFFE);
            checks++;
            if (cfg_err !== berr[k] || cfg_ready !== 1'b0) begin
                errors++;
                $display("FAIL bad_cfg_pulse %0d got err=%b rdy=%b exp err=%b rdy=0", k, cfg_err, cfg_ready, berr[k]);
            end
            tick();
            checks++;
            if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL bad_cfg_after %0d got err=%b rdy=%b exp err=0 rdy=1", k, cfg_err, cfg_ready);
            end
            for (int i = 0; i < 30; i++) begin
                tick();
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL bad_cfg_state %0d cycle %0d got %h exp %h", k, i, obs, expv);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            sample_en = ($urandom_range(0, 3) != 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
            cfg_addr = 3'($urandom_range(0, 7));
            cfg_data = $urandom;
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random cycle %0d got %h exp %h", i, obs, expv);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int first;
        sample_en = 1'b1;
        cfg_write(3'd0, 3'd0, 32'h3000_0000);
        cfg_write(3'd1, 3'd2, 32'hB);
        repeat (20) tick();
        #2 sys_rst_n = 1'b0;
        #1;
        m_reset();
        checks++;
        if ({dac_valid, dac_data, wrap_pulse, cfg_ready, cfg_err} !== 21'd0) begin
            errors++;
            $display("FAIL reset_async got %h exp 0", {dac_valid, dac_data, wrap_pulse, cfg_ready, cfg_err});
        end
        repeat (2) tick();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        first = -1;
        for (int i = 1; i <= 1300 && first < 0; i++) begin
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_restore cycle %0d got %h exp %h", i, obs, expv);
            end
            if (wrap_pulse[0] === 1'b1) first = i;
        end
        checks++;
        if (first != 1189) begin
            errors++;
            $display("FAIL reset_default_freq first_wrap got %0d exp 1189", first);
        end
    endtask

    initial begin
        test_reset();
        test_saw();
        test_pend_write();
        test_phase_sync();
        test_sweep();
        test_bad_cfg();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
